jtframe_sdram_sched: RTL

JTFRAME_SDRAM_SCHED -- requirements
Module: jtframe_sdram_sched

---
 rtl/jtframe_sdram_sched.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/jtframe_sdram_sched.sv
// SDRAM request scheduler: arbitrates four bank ports and the download port onto one controller command.
// Optional macro JTFRAME_SDRAM_BA0_PRIO_EN gives bank 0 every other grant; banks 1-3 rotate among themselves.
module jtframe_sdram_sched #(
  parameter int SDRAMW = 22,
  parameter int TOUT   = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              downloading,
  input  logic [3:0]        ba_rd,
  input  logic [3:0]        ba_wr,
  input  logic [SDRAMW-1:0] ba0_addr,
  input  logic [SDRAMW-1:0] ba1_addr,
  input  logic [SDRAMW-1:0] ba2_addr,
  input  logic [SDRAMW-1:0] ba3_addr,
  input  logic              prog_rd,
  input  logic              prog_we,
  input  logic [SDRAMW-1:0] prog_addr,
  input  logic [1:0]        prog_ba,
  output logic              cmd_vld,
  output logic              cmd_we,
  output logic [1:0]        cmd_ba,
  output logic [SDRAMW-1:0] cmd_addr,
  input  logic              cmd_ack,
  input  logic              cmd_rdy,
  output logic [3:0]        ba_ack,
  output logic [3:0]        ba_rdy,
  output logic              prog_ack,
  output logic              prog_rdy,
  output logic              busy,
  output logic              tout_err
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ISSUE = 2'd1, ST_WAIT = 2'd2} state_t;

  localparam logic [7:0] TOUT_C = 8'(TOUT);

  state_t            state_q;
  logic [1:0]        last_q;
  logic [1:0]        hi_q;
  logic              gprog_q;
  logic [7:0]        cnt_q;
  logic              cmd_vld_q, cmd_we_q, busy_q, tout_q, prog_ack_q, prog_rdy_q;
  logic [1:0]        cmd_ba_q;
  logic [SDRAMW-1:0] cmd_addr_q;
  logic [3:0]        ba_ack_q, ba_rdy_q;

  logic [3:0]        elig_s;
  logic              prog_elig_s;
  logic              win_vld_s;
  logic [1:0]        win_s;
  logic [SDRAMW-1:0] win_addr_s;

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    onehot = 4'b0001 << idx;
  endfunction

  assign elig_s      = (ba_rd | ba_wr) & {4{~downloading}};
  assign prog_elig_s = downloading & (prog_rd | prog_we);

  // Pick the winning bank for the next grant
  always_comb begin
    logic [1:0] cand_v;
    win_vld_s = 1'b0;
    win_s     = 2'd0;
    cand_v    = 2'd0;
`ifdef JTFRAME_SDRAM_BA0_PRIO_EN
    // bank 0 yields to the rotation right after its own grant, so it wins every other slot
    if (elig_s[0] && last_q != 2'd0) begin
      win_vld_s = 1'b1;
      win_s     = 2'd0;
    end else begin
      cand_v = hi_q;
      for (int k = 0; k < 3; k++) begin
        cand_v = (cand_v == 2'd3) ? 2'd1 : cand_v + 2'd1;
        if (!win_vld_s && elig_s[cand_v]) begin
          win_vld_s = 1'b1;
          win_s     = cand_v;
        end else begin
          win_vld_s = win_vld_s;
        end
      end
      if (!win_vld_s && elig_s[0]) begin
        win_vld_s = 1'b1;
        win_s     = 2'd0;
      end else begin
        win_vld_s = win_vld_s;
      end
    end
`else
    for (int k = 0; k < 4; k++) begin
      cand_v = last_q + 2'(k + 1);
      if (!win_vld_s && elig_s[cand_v]) begin
        win_vld_s = 1'b1;
        win_s     = cand_v;
      end else begin
        win_vld_s = win_vld_s;
      end
    end
`endif
  end

  // Address of the winning bank
  always_comb begin
    case (win_s)
      2'd0:    win_addr_s = ba0_addr;
      2'd1:    win_addr_s = ba1_addr;
      2'd2:    win_addr_s = ba2_addr;
      2'd3:    win_addr_s = ba3_addr;
      default: win_addr_s = ba0_addr;
    endcase
  end

  // Scheduler FSM with registered command and handshake outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      last_q     <= 2'd3;
      hi_q       <= 2'd3;
      gprog_q    <= 1'b0;
      cnt_q      <= 8'd0;
      cmd_vld_q  <= 1'b0;
      cmd_we_q   <= 1'b0;
      cmd_ba_q   <= 2'd0;
      cmd_addr_q <= '0;
      ba_ack_q   <= 4'd0;
      ba_rdy_q   <= 4'd0;
      prog_ack_q <= 1'b0;
      prog_rdy_q <= 1'b0;
      busy_q     <= 1'b0;
      tout_q     <= 1'b0;
    end else begin
      ba_ack_q   <= 4'd0;
      ba_rdy_q   <= 4'd0;
      prog_ack_q <= 1'b0;
      prog_rdy_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (prog_elig_s) begin
            gprog_q    <= 1'b1;
            cmd_vld_q  <= 1'b1;
            cmd_we_q   <= prog_we;
            cmd_ba_q   <= prog_ba;
            cmd_addr_q <= prog_addr;
            busy_q     <= 1'b1;
            state_q    <= ST_ISSUE;
          end else if (win_vld_s) begin
            gprog_q    <= 1'b0;
            cmd_vld_q  <= 1'b1;
            cmd_we_q   <= ba_wr[win_s];
            cmd_ba_q   <= win_s;
            cmd_addr_q <= win_addr_s;
            last_q     <= win_s;
            if (win_s != 2'd0) hi_q <= win_s;
            else               hi_q <= hi_q;
            busy_q     <= 1'b1;
            state_q    <= ST_ISSUE;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          if (cmd_ack || cmd_rdy) begin
            if (gprog_q) prog_ack_q <= 1'b1;
            else         ba_ack_q   <= onehot(cmd_ba_q);
            cmd_vld_q <= 1'b0;
            cnt_q     <= 8'd0;
            if (cmd_rdy) begin
              if (gprog_q) prog_rdy_q <= 1'b1;
              else         ba_rdy_q   <= onehot(cmd_ba_q);
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              state_q <= ST_WAIT;
            end
          end else begin
            state_q <= ST_ISSUE;
          end
        end
        ST_WAIT: begin
          if (cmd_rdy || cnt_q == TOUT_C) begin
            if (gprog_q) prog_rdy_q <= 1'b1;
            else         ba_rdy_q   <= onehot(cmd_ba_q);
            if (!cmd_rdy) tout_q <= 1'b1;
            else          tout_q <= tout_q;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q   <= cnt_q + 8'd1;
            state_q <= ST_WAIT;
          end
        end
        default: begin
          cmd_vld_q <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_vld  = cmd_vld_q;
  assign cmd_we   = cmd_we_q;
  assign cmd_ba   = cmd_ba_q;
  assign cmd_addr = cmd_addr_q;
  assign ba_ack   = ba_ack_q;
  assign ba_rdy   = ba_rdy_q;
  assign prog_ack = prog_ack_q;
  assign prog_rdy = prog_rdy_q;
  assign busy     = busy_q;
  assign tout_err = tout_q;

endmodule
